// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 message padder: FSM states, block geometry,
// and a byte-lane insert helper for little-endian word assembly.
package md5_pkg;

  typedef enum logic [2:0] {
    DATA   = 3'd0,
    PAD    = 3'd1,
    ZERO   = 3'd2,
    LEN_LO = 3'd3,
    LEN_HI = 3'd4
  } pad_state_e;

  localparam int unsigned MD5_BLK_WORDS = 16;
  localparam logic [5:0]  MD5_LEN_BC    = 6'd56;
  localparam logic [7:0]  MD5_PAD_BYTE  = 8'h80;

  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    case (off)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      2'd3:    res[31:24] = b;
      default: res        = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/md5_word_slot.sv
// One-entry output register with valid/ready handshake and block sideband.
// free_o tells the producer a load this cycle will not overwrite a pending word.
module md5_word_slot (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [3:0]  idx_i,
  input  logic        first_i,
  input  logic        last_i,
  input  logic        ready_i,
  output logic [31:0] word_o,
  output logic        valid_o,
  output logic [3:0]  idx_o,
  output logic        first_o,
  output logic        last_o,
  output logic        free_o
);

  logic [31:0] word_q;
  logic        valid_q;
  logic [3:0]  idx_q;
  logic        first_q;
  logic        last_q;

  // Slot contents: loaded by the padder, released on the consumer handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= 32'd0;
      valid_q <= 1'b0;
      idx_q   <= 4'd0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      valid_q <= 1'b1;
      idx_q   <= idx_i;
      first_q <= first_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign free_o  = !valid_q || ready_i;
  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign first_o = first_q;
  assign last_o  = last_q;

endmodule

// File: rtl/md5_padder.sv
// MD5 front end: packs message bytes little-endian into words, appends the
// 0x80 / zero-fill / 64-bit bit-length padding and emits 16-word blocks.
module md5_padder
  import md5_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        last_i,
  output logic        ready_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [3:0]  word_idx_o,
  output logic        blk_first_o,
  output logic        blk_last_o
);

  pad_state_e  state_q;
  logic [5:0]  bc_q;
  logic [60:0] len_q;
  logic [31:0] asm_q;
  logic        first_q;

  logic        slot_free_s;
  logic        step_ok_s;
  logic        step_s;
  logic [7:0]  step_byte_s;
  logic        load_s;
  logic [31:0] load_word_s;
  logic [3:0]  load_idx_s;
  logic        load_last_s;
  logic [5:0]  bc_inc_s;
  logic [63:0] bitlen_s;
  logic [31:0] asm_d;

  assign bitlen_s = {len_q, 3'b000};
  assign bc_inc_s = bc_q + 6'd1;
  assign asm_d    = put_byte(asm_q, bc_q[1:0], step_byte_s);

  // A byte only blocks when it would complete a word and the slot stays full.
  always_comb begin
    step_ok_s   = (bc_q[1:0] != 2'd3) || slot_free_s;
    step_s      = 1'b0;
    step_byte_s = 8'h00;
    load_s      = 1'b0;
    load_word_s = asm_d;
    load_idx_s  = bc_q[5:2];
    load_last_s = 1'b0;
    case (state_q)
      DATA: begin
        step_s      = valid_i && step_ok_s;
        step_byte_s = data_i;
      end
      PAD: begin
        step_s      = step_ok_s;
        step_byte_s = MD5_PAD_BYTE;
      end
      ZERO: begin
        step_s      = step_ok_s;
        step_byte_s = 8'h00;
      end
      LEN_LO: begin
        load_s      = slot_free_s;
        load_word_s = bitlen_s[31:0];
        load_idx_s  = 4'd14;
      end
      LEN_HI: begin
        load_s      = slot_free_s;
        load_word_s = bitlen_s[63:32];
        load_idx_s  = 4'd15;
        load_last_s = 1'b1;
      end
      default: begin
        step_s = 1'b0;
      end
    endcase
    if (step_s && (bc_q[1:0] == 2'd3)) begin
      load_s = 1'b1;
    end else begin
      load_s = load_s;
    end
  end

  assign ready_o = (state_q == DATA) && step_ok_s;

  // Padder FSM, block byte counter, message length and word assembly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DATA;
      bc_q    <= 6'd0;
      len_q   <= 61'd0;
      asm_q   <= 32'd0;
      first_q <= 1'b1;
    end else begin
      if (step_s) begin
        bc_q  <= bc_inc_s;
        asm_q <= (bc_q[1:0] == 2'd3) ? 32'd0 : asm_d;
      end else begin
        bc_q  <= bc_q;
      end
      if (load_s) begin
        first_q <= 1'b0;
      end else begin
        first_q <= first_q;
      end
      case (state_q)
        DATA: begin
          if (step_s) begin
            len_q <= len_q + 61'd1;
            if (last_i) state_q <= PAD;
          end
        end
        PAD: begin
          if (step_s) state_q <= (bc_inc_s == MD5_LEN_BC) ? LEN_LO : ZERO;
        end
        ZERO: begin
          if (step_s && (bc_inc_s == MD5_LEN_BC)) state_q <= LEN_LO;
        end
        LEN_LO: begin
          if (slot_free_s) begin
            bc_q    <= 6'd60;
            state_q <= LEN_HI;
          end
        end
        LEN_HI: begin
          // Word 15 leaves; the next accepted word starts a fresh message.
          if (slot_free_s) begin
            bc_q    <= 6'd0;
            len_q   <= 61'd0;
            first_q <= 1'b1;
            state_q <= DATA;
          end
        end
        default: state_q <= DATA;
      endcase
    end
  end

  md5_word_slot u_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_s),
    .word_i  (load_word_s),
    .idx_i   (load_idx_s),
    .first_i (first_q),
    .last_i  (load_last_s),
    .ready_i (word_ready_i),
    .word_o  (word_o),
    .valid_o (word_valid_o),
    .idx_o   (word_idx_o),
    .first_o (blk_first_o),
    .last_o  (blk_last_o),
    .free_o  (slot_free_s)
  );

endmodule
